// File: rtl/contador_pkg.sv
// Shared definitions for the contador counter family and its stream monitor.
//   CONTADOR_WIDTH : default width of the count bus
//   mon_state_t    : monitor FSM encoding (IDLE / ACQ / LOCK)
//   next_count()   : (value + 1) mod 2^width
package contador_pkg;

  localparam int unsigned CONTADOR_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } mon_state_t;

  function automatic logic [31:0] next_count(input logic [31:0] value,
                                             input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (value + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/monitor_contador_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk : rising-edge clock
//   rst : asynchronous reset, active-low
//   clr : synchronous clear to zero (priority over inc)
//   inc : increment request; dropped once q is all-ones
//   q   : count value
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/monitor_contador.sv
// Receive-side checker for a free-running modulo-2^WIDTH counter stream.
// Locks after LOCK_N consecutive correct increments (following one reference
// sample), then flags any skip, hold or jump.
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active-low
//   count_in   : count value under observation
//   sample_en  : count_in is sampled at this edge
//   clear      : synchronous clear of FSM and statistics (beats sample_en)
//   locked     : monitor is locked on a valid sequence
//   err_pulse  : one-cycle pulse per sequence error detected while locked
//   err_count  : saturating error count
//   wrap_count : saturating count of max->0 wraps seen while locked
//   expected   : next value the monitor expects
module monitor_contador
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH  = CONTADOR_WIDTH,
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              sample_en,
  input  logic              clear,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  expected
);

  localparam int unsigned GR_W = $clog2(LOCK_N + 1);

  mon_state_t      r_state, w_state_nx;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_expected;
  logic [GR_W-1:0]  r_good_run, w_good_run_nx;
  logic             r_locked, w_locked_nx;
  logic             r_err_pulse;
  logic             w_load;
  logic             w_err;
  logic             w_wrap;
  logic             w_match;

  // r_expected always holds prev+1, so matching is a direct compare
  assign w_match = (count_in == r_expected);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_good_run_nx = r_good_run;
    w_locked_nx   = r_locked;
    w_load        = 1'b0;
    w_err         = 1'b0;
    w_wrap        = 1'b0;
    if (clear) begin
      w_state_nx    = IDLE;
      w_good_run_nx = '0;
      w_locked_nx   = 1'b0;
    end else if (sample_en) begin
      w_load = 1'b1;
      case (r_state)
        IDLE: begin
          w_good_run_nx = '0;
          w_state_nx    = ACQ;
        end
        ACQ: begin
          if (w_match) begin
            w_good_run_nx = r_good_run + 1'b1;
            if (r_good_run == GR_W'(LOCK_N - 1)) begin
              w_state_nx  = LOCK;
              w_locked_nx = 1'b1;
            end
          end else begin
            w_good_run_nx = '0;
          end
        end
        LOCK: begin
          if (w_match) begin
            w_wrap = (r_prev == '1) && (count_in == '0);
          end else begin
            w_err         = 1'b1;
            w_locked_nx   = 1'b0;
            w_good_run_nx = '0;
            w_state_nx    = ACQ;
          end
        end
        default: begin
          w_state_nx    = IDLE;
          w_good_run_nx = '0;
          w_locked_nx   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev      <= '0;
      r_expected  <= '0;
      r_good_run  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_good_run  <= w_good_run_nx;
      r_locked    <= w_locked_nx;
      r_err_pulse <= w_err;
      if (clear) begin
        r_prev     <= '0;
        r_expected <= '0;
      end else if (w_load) begin
        r_prev     <= count_in;
        r_expected <= WIDTH'(next_count(32'(count_in), WIDTH));
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (w_err),
    .q   (err_count)
  );

  sat_counter #(.W(WRAP_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (w_wrap),
    .q   (wrap_count)
  );

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign expected  = r_expected;

endmodule

// File: tb/tb_monitor_contador.sv
module tb_monitor_contador;

  logic       clk;
  logic       rst;
  logic [2:0] count_in;
  logic       sample_en;
  logic       clear;
  logic       locked;
  logic       err_pulse;
  logic [1:0] err_count;
  logic [1:0] wrap_count;
  logic [2:0] expected;

  typedef struct {
    int         id;
    logic [8:0] exp;  // {locked, err_pulse, err_count, wrap_count, expected}
  } sb_t;

  sb_t q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  vec_id = 0;

  monitor_contador #(
    .WIDTH (3),
    .LOCK_N(4),
    .ERR_W (2),
    .WRAP_W(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .sample_en (sample_en),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .wrap_count(wrap_count),
    .expected  (expected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] actual_vec();
    return {locked, err_pulse, err_count, wrap_count, expected};
  endfunction

  task automatic compare(input string nm, input int id, input logic [8:0] req);
    logic [8:0] act;
    act = actual_vec();
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s%0d got lock=%b pulse=%b err=%0d wrap=%0d exp=%0d required lock=%b pulse=%b err=%0d wrap=%0d exp=%0d",
               nm, id, act[8], act[7], act[6:5], act[4:3], act[2:0],
               req[8], req[7], req[6:5], req[4:3], req[2:0]);
    end
  endtask

  // Monitor: one registered result per clock edge
  always @(posedge clk) begin
    sb_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      compare("vec", e.id, e.exp);
    end
  end

  task automatic step(input logic en, input logic clr, input logic [2:0] cnt,
                      input logic el, input logic ep, input logic [1:0] ee,
                      input logic [1:0] ew, input logic [2:0] ex);
    sb_t e;
    @(negedge clk);
    sample_en = en;
    clear     = clr;
    count_in  = cnt;
    e.id  = vec_id;
    e.exp = {el, ep, ee, ew, ex};
    vec_id++;
    q.push_back(e);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain got %0d pending required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst       = 1'b0;
    sample_en = 1'b0;
    clear     = 1'b0;
    count_in  = 3'd0;
    #2;
    compare("rst_hold", 0, 9'd0);
    repeat (2) begin
      @(negedge clk);
      sample_en = ~sample_en;
      count_in  = count_in + 3'd3;
    end
    #1;
    compare("rst_hold", 1, 9'd0);
    @(negedge clk);
    rst       = 1'b1;
    sample_en = 1'b0;

    // idle after reset release
    repeat (5) step(1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0);

    // acquire and lock, one wrap while locked
    step(1, 0, 3'd0, 0, 0, 2'd0, 2'd0, 3'd1);
    step(1, 0, 3'd1, 0, 0, 2'd0, 2'd0, 3'd2);
    step(1, 0, 3'd2, 0, 0, 2'd0, 2'd0, 3'd3);
    step(1, 0, 3'd3, 0, 0, 2'd0, 2'd0, 3'd4);
    step(1, 0, 3'd4, 1, 0, 2'd0, 2'd0, 3'd5);
    step(1, 0, 3'd5, 1, 0, 2'd0, 2'd0, 3'd6);
    step(1, 0, 3'd6, 1, 0, 2'd0, 2'd0, 3'd7);
    step(1, 0, 3'd7, 1, 0, 2'd0, 2'd0, 3'd0);
    step(1, 0, 3'd0, 1, 0, 2'd0, 2'd1, 3'd1);

    // skip 3->5, relock; 7->0 in ACQ is not a wrap
    step(1, 0, 3'd1, 1, 0, 2'd0, 2'd1, 3'd2);
    step(1, 0, 3'd2, 1, 0, 2'd0, 2'd1, 3'd3);
    step(1, 0, 3'd3, 1, 0, 2'd0, 2'd1, 3'd4);
    step(1, 0, 3'd5, 0, 1, 2'd1, 2'd1, 3'd6);
    step(1, 0, 3'd6, 0, 0, 2'd1, 2'd1, 3'd7);
    step(1, 0, 3'd7, 0, 0, 2'd1, 2'd1, 3'd0);
    step(1, 0, 3'd0, 0, 0, 2'd1, 2'd1, 3'd1);
    step(1, 0, 3'd1, 1, 0, 2'd1, 2'd1, 3'd2);

    // upstream counter reset: 3,0,0,1
    step(1, 0, 3'd2, 1, 0, 2'd1, 2'd1, 3'd3);
    step(1, 0, 3'd3, 1, 0, 2'd1, 2'd1, 3'd4);
    step(1, 0, 3'd0, 0, 1, 2'd2, 2'd1, 3'd1);
    step(1, 0, 3'd0, 0, 0, 2'd2, 2'd1, 3'd1);
    step(1, 0, 3'd1, 0, 0, 2'd2, 2'd1, 3'd2);

    // error counter saturation (2 bits), pulse still fires
    step(1, 0, 3'd2, 0, 0, 2'd2, 2'd1, 3'd3);
    step(1, 0, 3'd3, 0, 0, 2'd2, 2'd1, 3'd4);
    step(1, 0, 3'd4, 1, 0, 2'd2, 2'd1, 3'd5);
    step(1, 0, 3'd7, 0, 1, 2'd3, 2'd1, 3'd0);
    step(0, 0, 3'd3, 0, 0, 2'd3, 2'd1, 3'd0);
    step(1, 0, 3'd0, 0, 0, 2'd3, 2'd1, 3'd1);
    step(1, 0, 3'd1, 0, 0, 2'd3, 2'd1, 3'd2);
    step(1, 0, 3'd2, 0, 0, 2'd3, 2'd1, 3'd3);
    step(1, 0, 3'd3, 1, 0, 2'd3, 2'd1, 3'd4);
    step(1, 0, 3'd6, 0, 1, 2'd3, 2'd1, 3'd7);
    step(1, 0, 3'd7, 0, 0, 2'd3, 2'd1, 3'd0);
    step(1, 0, 3'd0, 0, 0, 2'd3, 2'd1, 3'd1);
    step(1, 0, 3'd1, 0, 0, 2'd3, 2'd1, 3'd2);
    step(1, 0, 3'd2, 1, 0, 2'd3, 2'd1, 3'd3);
    step(1, 0, 3'd2, 0, 1, 2'd3, 2'd1, 3'd3);

    // relock, then wrap counter saturation (2 bits)
    step(1, 0, 3'd3, 0, 0, 2'd3, 2'd1, 3'd4);
    step(1, 0, 3'd4, 0, 0, 2'd3, 2'd1, 3'd5);
    step(1, 0, 3'd5, 0, 0, 2'd3, 2'd1, 3'd6);
    step(1, 0, 3'd6, 1, 0, 2'd3, 2'd1, 3'd7);
    step(1, 0, 3'd7, 1, 0, 2'd3, 2'd1, 3'd0);
    step(1, 0, 3'd0, 1, 0, 2'd3, 2'd2, 3'd1);
    for (int p = 0; p < 2; p++) begin
      for (int i = 1; i <= 8; i++) begin
        logic [2:0] v;
        logic [1:0] w;
        v = 3'(i % 8);
        w = (p == 0 && i < 8) ? 2'd2 : 2'd3;
        step(1, 0, v, 1, 0, 2'd3, w, 3'(v + 3'd1));
      end
    end

    // clear beats sample_en; next sample is only a reference
    step(1, 1, 3'd1, 0, 0, 2'd0, 2'd0, 3'd0);
    step(0, 0, 3'd2, 0, 0, 2'd0, 2'd0, 3'd0);
    step(1, 0, 3'd5, 0, 0, 2'd0, 2'd0, 3'd6);
    step(1, 0, 3'd6, 0, 0, 2'd0, 2'd0, 3'd7);
    drain();

    // asynchronous reset mid-acquisition, checked before any clock edge
    @(negedge clk);
    sample_en = 1'b0;
    #1;
    compare("pre_rst", 0, {1'b0, 1'b0, 2'd0, 2'd0, 3'd7});
    #1;
    rst = 1'b0;
    #1;
    compare("async_rst", 0, 9'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/monitor_contador.md
Name: monitor_contador

Overview:
Receive-side checker for the free-running modulo-2^WIDTH counter stream. Samples a count bus, locks onto a valid increment sequence, and flags any skip, hold or jump once locked. Counts wrap-arounds and errors for the bench and the system status logic. Sits downstream of any contador instance, in the same clock domain.

Parameters:
WIDTH, 3, width of the monitored count bus; sequence is modulo 2^WIDTH
LOCK_N, 4, consecutive correct increments required to assert locked (>=1)
ERR_W, 8, width of saturating error counter
WRAP_W, 8, width of saturating wrap counter

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-low (0 = reset)
count_in  input  WIDTH  count value under observation
sample_en  input  1  1 = count_in is sampled at this clk edge
clear  input  1  synchronous clear of FSM and statistics
locked  output  1  1 = monitor is locked on a valid sequence
err_pulse  output  1  one-cycle pulse per detected sequence error
err_count  output  ERR_W  saturating number of errors since reset/clear
wrap_count  output  WRAP_W  saturating number of max->0 wraps seen while locked
expected  output  WIDTH  next value the monitor expects (prev+1 mod 2^WIDTH)

Behaviour:
- Reset (rst=0, async): state=IDLE, prev=0, good_run=0; locked=0, err_pulse=0, err_count=0, wrap_count=0, expected=0. Reset mid-operation discards all history immediately, with no err_pulse.
- All outputs are registered. A sample taken at edge k is reflected on the outputs after edge k (latency 1 clk).
- sample_en=0: no state, counter or prev change; err_pulse=0.
- "Match" is defined as count_in == (prev+1) mod 2^WIDTH, using WIDTH-bit wrap arithmetic.
- FSM states: IDLE, ACQ, LOCK.
- IDLE: on the first sample, prev<=count_in, good_run<=0, go to ACQ. No error is possible.
- ACQ: on a match, good_run++ and prev<=count_in. When good_run reaches LOCK_N, go to LOCK and set locked<=1. On a mismatch, good_run<=0 and prev<=count_in, with no error (still acquiring).
- LOCK: on a match, prev<=count_in. If prev == 2^WIDTH-1 and count_in == 0, then wrap_count++ (saturating).
- LOCK mismatch (a skip, a hold/repeat, or a counter reset back to 0): err_pulse<=1 for exactly one cycle; err_count++ (saturating at all-ones); locked<=0; prev<=count_in; good_run<=0; go to ACQ.
- expected = (prev+1) mod 2^WIDTH, updated with prev. It is 0 in reset and after clear.
- clear=1: has priority over sample_en in the same cycle, and the sample is ignored. Return to the reset values except that rst is not involved. No err_pulse.
- Saturating counters hold at max. Any further increment is dropped silently.
- The first sample after IDLE counts only as a reference. Minimum time to lock is LOCK_N+1 samples.

Decomposition:
- Package contador_pkg holds:
  - FSM state localparams (IDLE=2'd0, ACQ=2'd1, LOCK=2'd2).
  - Function next_count(value, width), returning (value+1) mod 2^width.
  - Default WIDTH=3, shared with contador.
- One sub-module, sat_counter (parameter W; inputs clk, rst, clr, inc; output q). It saturates at all-ones and uses the same async active-low reset. It is instantiated twice, for err_count and wrap_count.

Test Plan:
1. rst=0 for 10 ns with sample_en toggling -> all outputs 0. Release reset, sample_en=0 for 5 cycles -> outputs remain 0, state IDLE.
2. WIDTH=3, LOCK_N=4, sample_en=1, count_in=0,1,2,3,4,5,6,7,0 -> locked=1 the cycle after sample '4'. wrap_count=1 after sample '0'. err_count=0, expected=1 at the end.
3. Locked, then feed 2,3,5,6,7,0,1 -> err_pulse high for exactly one cycle after '5'; err_count=1 and locked=0. Relock the cycle after '1' (4 matches: 6,7,0,1). wrap_count is incremented only if already locked, so it is unchanged by the 7->0 in ACQ.
4. Locked at value 3, then drive contador's reset so the stream is 3,0,0,1 -> err_pulse after the first '0' (count 1). The second '0' occurs in ACQ and causes no further error. err_count=1.
5. ERR_W=2: produce 5 errors, each separated by a relock -> err_count sequence 1,2,3,3,3. err_pulse still fires 5 times.
6. clear=1 together with sample_en=1 while locked with err_count=2 -> next cycle locked=0, err_count=0, wrap_count=0, expected=0, no err_pulse. Then assert rst=0 mid-acquisition -> outputs go 0 immediately, without waiting for a clk edge.
